// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared lsu dtype codes, funct3 codes, exception causes and mem-stage states
package lsu_pkg;

    localparam logic [2:0] BYTE               = 3'b000;
    localparam logic [2:0] HALF_WORD          = 3'b001;
    localparam logic [2:0] FULL_WORD          = 3'b010;
    localparam logic [2:0] BYTE_UNSIGNED      = 3'b011;
    localparam logic [2:0] HALF_WORD_UNSIGNED = 3'b100;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        EXC_NONE       = 2'b00,
        EXC_MISALIGNED = 2'b01,
        EXC_ILLEGAL    = 2'b10,
        EXC_RANGE      = 2'b11
    } exc_cause_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_WB,
        ST_EXC
    } mem_state_e;

endpackage

// File: rtl/lsu_dtype_decode.sv
// rtl/lsu_dtype_decode.sv - funct3/is_store to lsu dtype, legality and alignment mask
module lsu_dtype_decode
    import lsu_pkg::*;
#(
    parameter int DTYPE_W = 3
) (
    input  logic [2:0]         funct3,
    input  logic               is_store,
    output logic [DTYPE_W-1:0] dtype,
    output logic               legal,
    output logic [1:0]         align_mask
);

    // align_mask selects the low ea bits that must be zero for the access size
    always_comb begin
        dtype      = '0;
        legal      = 1'b0;
        align_mask = 2'b00;
        case (funct3)
            F3_B: begin
                dtype = DTYPE_W'(BYTE);
                legal = 1'b1;
            end
            F3_H: begin
                dtype      = DTYPE_W'(HALF_WORD);
                legal      = 1'b1;
                align_mask = 2'b01;
            end
            F3_W: begin
                dtype      = DTYPE_W'(FULL_WORD);
                legal      = 1'b1;
                align_mask = 2'b11;
            end
            F3_BU: begin
                dtype = DTYPE_W'(BYTE_UNSIGNED);
                legal = !is_store;
            end
            F3_HU: begin
                dtype      = DTYPE_W'(HALF_WORD_UNSIGNED);
                legal      = !is_store;
                align_mask = 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - memory-stage sequencer between execute, lsu and writeback
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int ADDRESS_SPACE  = 4096,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_DATA_TYPES = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_is_store,
    input  logic [2:0]                        req_funct3,
    input  logic [DATA_WIDTH-1:0]             req_base,
    input  logic [DATA_WIDTH-1:0]             req_offset,
    input  logic [DATA_WIDTH-1:0]             req_wdata,
    input  logic [4:0]                        req_rd,
    output logic [$clog2(ADDRESS_SPACE)-1:0]  lsu_addr,
    output logic [DATA_WIDTH-1:0]             lsu_wdata,
    output logic                              lsu_we,
    output logic [$clog2(NUM_DATA_TYPES)-1:0] lsu_dtype,
    input  logic [DATA_WIDTH-1:0]             lsu_rdata,
    output logic                              wb_valid,
    input  logic                              wb_ready,
    output logic [4:0]                        wb_rd,
    output logic [DATA_WIDTH-1:0]             wb_data,
    output logic                              exc_valid,
    output logic [1:0]                        exc_cause,
    output logic [DATA_WIDTH-1:0]             exc_addr
);

    localparam int AW  = $clog2(ADDRESS_SPACE);
    localparam int DTW = $clog2(NUM_DATA_TYPES);

    mem_state_e            state, state_n;
    logic [DATA_WIDTH-1:0] ea;
    logic [DTW-1:0]        dec_dtype;
    logic                  dec_legal;
    logic [1:0]            dec_align_mask;
    logic                  misaligned, out_of_range;
    exc_cause_e            fault_cause, exc_cause_q;
    logic                  is_store_q;
    logic [4:0]            rd_q;

    assign ea = req_base + req_offset;

    lsu_dtype_decode #(.DTYPE_W(DTW)) u_decode (
        .funct3     (req_funct3),
        .is_store   (req_is_store),
        .dtype      (dec_dtype),
        .legal      (dec_legal),
        .align_mask (dec_align_mask)
    );

    assign misaligned   = |(ea[1:0] & dec_align_mask);
    assign out_of_range = ea >= DATA_WIDTH'(ADDRESS_SPACE);

    always_comb begin
        fault_cause = EXC_NONE;
        if (!dec_legal)        fault_cause = EXC_ILLEGAL;
        else if (misaligned)   fault_cause = EXC_MISALIGNED;
        else if (out_of_range) fault_cause = EXC_RANGE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (req_valid) state_n = (fault_cause != EXC_NONE) ? ST_EXC : ST_ACCESS;
            ST_ACCESS:  state_n = is_store_q ? ST_IDLE : ST_CAPTURE;
            ST_CAPTURE: state_n = ST_WB;
            ST_WB:      if (wb_ready) state_n = ST_IDLE;
            ST_EXC:     state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // Faulting requests only load the exception registers so the lsu bus keeps its last value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lsu_addr    <= '0;
            lsu_dtype   <= '0;
            lsu_wdata   <= '0;
            is_store_q  <= 1'b0;
            rd_q        <= '0;
            wb_data     <= '0;
            exc_cause_q <= EXC_NONE;
            exc_addr    <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                if (fault_cause != EXC_NONE) begin
                    exc_cause_q <= fault_cause;
                    exc_addr    <= ea;
                end else begin
                    lsu_addr   <= ea[AW-1:0];
                    lsu_dtype  <= dec_dtype;
                    lsu_wdata  <= req_wdata;
                    is_store_q <= req_is_store;
                    rd_q       <= req_rd;
                end
            end
            if (state == ST_CAPTURE) wb_data <= lsu_rdata;
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign lsu_we    = (state == ST_ACCESS) && is_store_q;
    assign wb_valid  = (state == ST_WB);
    assign wb_rd     = rd_q;
    assign exc_valid = (state == ST_EXC);
    assign exc_cause = exc_cause_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed vector bench for lsu_mem_stage with a behavioural lsu memory
module tb_lsu_mem_stage;

    localparam int K_ST = 0;
    localparam int K_LD = 1;
    localparam int K_EX = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_base = '0;
    logic [31:0] req_offset = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic [11:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_we;
    logic [2:0]  lsu_dtype;
    logic [31:0] lsu_rdata = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    int n_vec = 0;
    int n_checks = 0;
    int n_err = 0;

    lsu_mem_stage #(
        .ADDRESS_SPACE  (4096),
        .DATA_WIDTH     (32),
        .NUM_DATA_TYPES (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_base     (req_base),
        .req_offset   (req_offset),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_we       (lsu_we),
        .lsu_dtype    (lsu_dtype),
        .lsu_rdata    (lsu_rdata),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .exc_valid    (exc_valid),
        .exc_cause    (exc_cause),
        .exc_addr     (exc_addr)
    );

    always #5 clk = ~clk;

    // Byte-addressed little-endian lsu with a one-cycle registered, extending read port
    logic [7:0]  mem [0:4095];
    logic [11:0] a1, a2, a3;
    logic [31:0] mem_word;
    assign a1 = lsu_addr + 12'd1;
    assign a2 = lsu_addr + 12'd2;
    assign a3 = lsu_addr + 12'd3;
    assign mem_word = {mem[a3], mem[a2], mem[a1], mem[lsu_addr]};

    always @(posedge clk) begin
        if (lsu_we) begin
            mem[lsu_addr] <= lsu_wdata[7:0];
            if (lsu_dtype == 3'b001 || lsu_dtype == 3'b010) mem[a1] <= lsu_wdata[15:8];
            if (lsu_dtype == 3'b010) begin
                mem[a2] <= lsu_wdata[23:16];
                mem[a3] <= lsu_wdata[31:24];
            end
        end
        case (lsu_dtype)
            3'b000:  lsu_rdata <= {{24{mem_word[7]}}, mem_word[7:0]};
            3'b001:  lsu_rdata <= {{16{mem_word[15]}}, mem_word[15:0]};
            3'b011:  lsu_rdata <= {24'h0, mem_word[7:0]};
            3'b100:  lsu_rdata <= {16'h0, mem_word[15:0]};
            default: lsu_rdata <= mem_word;
        endcase
    end

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          kind;
        logic [2:0]  dt;
        logic [31:0] ea;
        logic [31:0] data;
        logic [1:0]  cause;
    } vec_t;

    vec_t tv [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        req_is_store = v.st;
        req_funct3   = v.f3;
        req_base     = v.base;
        req_offset   = v.off;
        req_wdata    = v.wdata;
        req_rd       = v.rd;
        req_valid    = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        n_vec++;
        @(negedge clk);
        drive_req(v);
        chk({p, ".req_ready_idle"}, {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        case (v.kind)
            K_ST: begin
                chk({p, ".lsu_we"},    {31'b0, lsu_we}, 32'd1);
                chk({p, ".lsu_addr"},  {20'b0, lsu_addr}, {20'b0, v.ea[11:0]});
                chk({p, ".lsu_dtype"}, {29'b0, lsu_dtype}, {29'b0, v.dt});
                chk({p, ".lsu_wdata"}, lsu_wdata, v.wdata);
                chk({p, ".req_ready_busy"}, {31'b0, req_ready}, 32'd0);
                @(negedge clk);
                chk({p, ".lsu_we_after"}, {31'b0, lsu_we}, 32'd0);
                chk({p, ".req_ready_after"}, {31'b0, req_ready}, 32'd1);
            end
            K_LD: begin
                chk({p, ".lsu_we"},    {31'b0, lsu_we}, 32'd0);
                chk({p, ".lsu_addr"},  {20'b0, lsu_addr}, {20'b0, v.ea[11:0]});
                chk({p, ".lsu_dtype"}, {29'b0, lsu_dtype}, {29'b0, v.dt});
                @(negedge clk);
                chk({p, ".wb_valid_capture"}, {31'b0, wb_valid}, 32'd0);
                chk({p, ".lsu_addr_hold"}, {20'b0, lsu_addr}, {20'b0, v.ea[11:0]});
                @(negedge clk);
                chk({p, ".wb_valid"}, {31'b0, wb_valid}, 32'd1);
                chk({p, ".wb_rd"},    {27'b0, wb_rd}, {27'b0, v.rd});
                chk({p, ".wb_data"},  wb_data, v.data);
                @(negedge clk);
                chk({p, ".wb_valid_after"}, {31'b0, wb_valid}, 32'd0);
                chk({p, ".req_ready_after"}, {31'b0, req_ready}, 32'd1);
            end
            default: begin
                chk({p, ".exc_valid"}, {31'b0, exc_valid}, 32'd1);
                chk({p, ".exc_cause"}, {30'b0, exc_cause}, {30'b0, v.cause});
                chk({p, ".exc_addr"},  exc_addr, v.ea);
                chk({p, ".lsu_we"},    {31'b0, lsu_we}, 32'd0);
                @(negedge clk);
                chk({p, ".exc_valid_after"}, {31'b0, exc_valid}, 32'd0);
                chk({p, ".req_ready_after"}, {31'b0, req_ready}, 32'd1);
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            st   f3      base          off           wdata         rd    kind  dt      ea            data          cause
        tv[0]  = '{1'b1, 3'b010, 32'h0,        32'h8,        32'hA0000F12, 5'd0, K_ST, 3'b010, 32'h008,      32'h0,        2'b00};
        tv[1]  = '{1'b0, 3'b010, 32'h4,        32'h4,        32'h0,        5'd5, K_LD, 3'b010, 32'h008,      32'hA0000F12, 2'b00};
        tv[2]  = '{1'b1, 3'b000, 32'h10,       32'hB,        32'h123456CB, 5'd0, K_ST, 3'b000, 32'h01B,      32'h0,        2'b00};
        tv[3]  = '{1'b0, 3'b000, 32'h1B,       32'h0,        32'h0,        5'd7, K_LD, 3'b000, 32'h01B,      32'hFFFFFFCB, 2'b00};
        tv[4]  = '{1'b0, 3'b100, 32'h20,       32'hFFFFFFFB, 32'h0,        5'd8, K_LD, 3'b011, 32'h01B,      32'h000000CB, 2'b00};
        tv[5]  = '{1'b0, 3'b001, 32'h13,       32'h0,        32'h0,        5'd1, K_EX, 3'b000, 32'h13,       32'h0,        2'b01};
        tv[6]  = '{1'b1, 3'b100, 32'h40,       32'h0,        32'h55,       5'd0, K_EX, 3'b000, 32'h40,       32'h0,        2'b10};
        tv[7]  = '{1'b0, 3'b010, 32'h1000,     32'h0,        32'h0,        5'd2, K_EX, 3'b000, 32'h1000,     32'h0,        2'b11};
        tv[8]  = '{1'b0, 3'b011, 32'h1000,     32'h1,        32'h0,        5'd2, K_EX, 3'b000, 32'h1001,     32'h0,        2'b10};
        tv[9]  = '{1'b0, 3'b010, 32'h1002,     32'h0,        32'h0,        5'd2, K_EX, 3'b000, 32'h1002,     32'h0,        2'b01};
        tv[10] = '{1'b1, 3'b001, 32'h0,        32'h2,        32'h0000BEEF, 5'd0, K_ST, 3'b001, 32'h002,      32'h0,        2'b00};
        tv[11] = '{1'b0, 3'b101, 32'h2,        32'h0,        32'h0,        5'd10,K_LD, 3'b100, 32'h002,      32'h0000BEEF, 2'b00};
        tv[12] = '{1'b0, 3'b001, 32'h1,        32'h1,        32'h0,        5'd11,K_LD, 3'b001, 32'h002,      32'hFFFFBEEF, 2'b00};
        tv[13] = '{1'b1, 3'b010, 32'hEF0,      32'h0,        32'h000000AB, 5'd0, K_ST, 3'b010, 32'hEF0,      32'h0,        2'b00};
        tv[14] = '{1'b0, 3'b010, 32'hEF0,      32'h0,        32'h0,        5'd12,K_LD, 3'b010, 32'hEF0,      32'h000000AB, 2'b00};
        tv[15] = '{1'b1, 3'b010, 32'hFF0,      32'hC,        32'h55AA1234, 5'd0, K_ST, 3'b010, 32'hFFC,      32'h0,        2'b00};
        tv[16] = '{1'b0, 3'b010, 32'hFFC,      32'h0,        32'h0,        5'd31,K_LD, 3'b010, 32'hFFC,      32'h55AA1234, 2'b00};
        tv[17] = '{1'b1, 3'b101, 32'h8,        32'h0,        32'h0,        5'd0, K_EX, 3'b000, 32'h8,        32'h0,        2'b10};
        tv[18] = '{1'b0, 3'b110, 32'h8,        32'h0,        32'h0,        5'd3, K_EX, 3'b000, 32'h8,        32'h0,        2'b10};
        tv[19] = '{1'b1, 3'b010, 32'hFFFFFFFC, 32'h10,       32'h0C0C0C0C, 5'd0, K_ST, 3'b010, 32'h00C,      32'h0,        2'b00};

        @(negedge clk);
        chk("reset.req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset.lsu_we",    {31'b0, lsu_we}, 32'd0);
        chk("reset.wb_valid",  {31'b0, wb_valid}, 32'd0);
        chk("reset.exc_valid", {31'b0, exc_valid}, 32'd0);
        chk("reset.lsu_addr",  {20'b0, lsu_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) apply(tv[i], i);

        // Writeback backpressure: LW from 0x8 with wb_ready low for five WB cycles
        n_vec++;
        wb_ready = 1'b0;
        v = '{1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 5'd9, K_LD, 3'b010, 32'h8, 32'hA0000F12, 2'b00};
        @(negedge clk);
        drive_req(v);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d.wb_valid", c), {31'b0, wb_valid}, 32'd1);
            chk($sformatf("bp%0d.wb_data", c), wb_data, 32'hA0000F12);
            chk($sformatf("bp%0d.wb_rd", c), {27'b0, wb_rd}, 32'd9);
            chk($sformatf("bp%0d.req_ready", c), {31'b0, req_ready}, 32'd0);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("bp.release_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("bp.release_req_ready", {31'b0, req_ready}, 32'd1);

        // Reset asserted while the load is in CAPTURE
        n_vec++;
        @(negedge clk);
        drive_req(v);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst.req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst.lsu_we",    {31'b0, lsu_we}, 32'd0);
        chk("rst.wb_valid",  {31'b0, wb_valid}, 32'd0);
        chk("rst.exc_valid", {31'b0, exc_valid}, 32'd0);
        chk("rst.lsu_addr",  {20'b0, lsu_addr}, 32'd0);
        chk("rst.lsu_dtype", {29'b0, lsu_dtype}, 32'd0);
        chk("rst.lsu_wdata", lsu_wdata, 32'd0);
        chk("rst.wb_data",   wb_data, 32'd0);
        chk("rst.wb_rd",     {27'b0, wb_rd}, 32'd0);
        chk("rst.exc_addr",  exc_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d.wb_valid", c), {31'b0, wb_valid}, 32'd0);
            chk($sformatf("rst_after%0d.req_ready", c), {31'b0, req_ready}, 32'd1);
        end

        // Reset leaves the lsu memory intact: earlier word at 0x8 still reads back
        apply(tv[1], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
